// File: rtl/mem_1r1w_masked_tiled_pkg.sv
// Shared types, constants and sizing helpers for the tiled 1R1W masked memory.
package mem_tiling_pkg;

  // Wrapper sequencer: zero-fill pass after reset, then normal operation.
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } init_state_e;

  // Macro strap values: extra margin adjust, collision logic enabled,
  // active-low test/bypass enables parked inactive.
  localparam logic [2:0] MACRO_EMA      = 3'd3;
  localparam logic       MACRO_COLLDISN = 1'b1;
  localparam logic       MACRO_PIN_OFF  = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int calc_rows(input int depth, input int macro_depth);
    return depth / macro_depth;
  endfunction

  function automatic int calc_cols(input int width, input int macro_width);
    return ceil_div(width, macro_width);
  endfunction

  function automatic int calc_mw(input int width, input int mask_gran);
    return ceil_div(width, mask_gran);
  endfunction

endpackage

// File: rtl/mem_1r1w_masked_tiled_if.sv
// Read/write port bundle for the tiled memory.
// Handshake: there is no backpressure. While ready is high, R0_en and W0_en
// are each accepted on every rising clock edge they are sampled high; while
// ready is low they are dropped. R0_valid pulses for exactly one cycle per
// accepted read, in request order, with R0_data valid in that same cycle.
interface mem_1r1w_masked_tiled_if #(
  parameter int AW    = 7,
  parameter int WIDTH = 136,
  parameter int MW    = 17
) ();
  logic [AW-1:0]    R0_addr;
  logic             R0_en;
  logic [WIDTH-1:0] R0_data;
  logic             R0_valid;
  logic [AW-1:0]    W0_addr;
  logic             W0_en;
  logic [WIDTH-1:0] W0_data;
  logic [MW-1:0]    W0_mask;
  logic             ready;

  modport master (
    output R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    input  R0_data, R0_valid, ready
  );

  modport slave (
    input  R0_addr, R0_en, W0_addr, W0_en, W0_data, W0_mask,
    output R0_data, R0_valid, ready
  );
endinterface

// File: rtl/mem_1r1w_masked_tiled_bank.sv
// One macro tile: straps plus active-high to active-low enable conversion.
module mem_1r1w_masked_bank
  import mem_tiling_pkg::*;
#(
  parameter int MACRO_DEPTH = 32,
  parameter int MACRO_WIDTH = 128,
  parameter int ADDR_W      = clog2(MACRO_DEPTH)
) (
  input  logic                   clock,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [MACRO_WIDTH-1:0] rd_data,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [MACRO_WIDTH-1:0] wr_data,
  input  logic [MACRO_WIDTH-1:0] wr_bit_en
);
  rf2_32x128_wm1 u_macro (
    .CLKA     (clock),
    .CENA     (~rd_en),
    .AA       (rd_addr),
    .QA       (rd_data),
    .CLKB     (clock),
    .CENB     (~wr_en),
    .AB       (wr_addr),
    .DB       (wr_data),
    .WENB     (~wr_bit_en),
    .EMAA     (MACRO_EMA),
    .EMAB     (MACRO_EMA),
    .TENA     (MACRO_PIN_OFF),
    .TENB     (MACRO_PIN_OFF),
    .BENA     (MACRO_PIN_OFF),
    .COLLDISN (MACRO_COLLDISN)
  );
endmodule

// File: rtl/rf2_32x128_wm1.sv
// Behavioural model of the 32x128 two-port bit-write-mask register-file macro.
// Port A reads, port B writes; enables are active-low. With collision logic
// enabled a same-edge read of the written word returns the old contents.
module rf2_32x128_wm1 (
  input  logic         CLKA,
  input  logic         CENA,
  input  logic [4:0]   AA,
  output logic [127:0] QA,
  input  logic         CLKB,
  input  logic         CENB,
  input  logic [4:0]   AB,
  input  logic [127:0] DB,
  input  logic [127:0] WENB,
  input  logic [2:0]   EMAA,
  input  logic [2:0]   EMAB,
  input  logic         TENA,
  input  logic         TENB,
  input  logic         BENA,
  input  logic         COLLDISN
);
  logic [127:0] mem [32];
  logic         unused_straps;

  assign unused_straps = ^{EMAA, EMAB, TENA, TENB, BENA, COLLDISN};

  // Synchronous read port; output holds when not enabled.
  always_ff @(posedge CLKA) begin
    if (!CENA) QA <= mem[AA];
  end

  // Synchronous write port; each cleared WENB bit writes that bit.
  always_ff @(posedge CLKB) begin
    if (!CENB) mem[AB] <= (mem[AB] & WENB) | (DB & ~WENB);
  end
endmodule

// File: rtl/mem_1r1w_masked_tiled.sv
// DEPTH x WIDTH byte-masked 1R1W memory tiled from fixed macros, with a
// zero-fill sequencer, registered row-select read mux and collision forwarding.
module mem_1r1w_masked_tiled
  import mem_tiling_pkg::*;
#(
  parameter int DEPTH         = 128,
  parameter int WIDTH         = 136,
  parameter int MASK_GRAN     = 8,
  parameter int MACRO_DEPTH   = 32,
  parameter int MACRO_WIDTH   = 128,
  parameter bit OUT_REG       = 1'b1,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset,
  mem_1r1w_masked_tiled_if.slave         bus,
  output init_state_e                    dbg_state
);
  localparam int AW   = clog2(DEPTH);
  localparam int MDW  = clog2(MACRO_DEPTH);
  localparam int MW   = calc_mw(WIDTH, MASK_GRAN);
  localparam int ROWS = calc_rows(DEPTH, MACRO_DEPTH);
  localparam int COLS = calc_cols(WIDTH, MACRO_WIDTH);
  localparam int PW   = COLS * MACRO_WIDTH;
  localparam int RW   = (ROWS > 1) ? clog2(ROWS) : 1;

  function automatic logic [WIDTH-1:0] expand_mask(input logic [MW-1:0] m);
    logic [WIDTH-1:0] b;
    for (int i = 0; i < WIDTH; i++) b[i] = m[i / MASK_GRAN];
    return b;
  endfunction

  init_state_e      state_q, state_d;
  logic [MDW-1:0]   init_cnt_q, init_cnt_d;
  logic             rd_v_q, rd_v_d;
  logic [RW-1:0]    rd_row_q, rd_row_d;
  logic             coll_q, coll_d;
  logic [WIDTH-1:0] coll_data_q, coll_data_d;
  logic [MW-1:0]    coll_mask_q, coll_mask_d;

  logic             in_init, rd_req, wr_req, collide;
  logic [RW-1:0]    rd_row, wr_row;
  logic [MDW-1:0]   a_addr, b_addr;
  logic [PW-1:0]    b_data, b_bit_en;
  logic [ROWS-1:0]  rd_en, wr_en;
  logic [MACRO_WIDTH-1:0] qa [ROWS][COLS];
  logic [PW-1:0]    row_full;
  logic [WIDTH-1:0] coll_bits, merged;

  // State, init counter and read/collision pipeline registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= INIT_ON_RESET ? INIT : RUN;
      init_cnt_q  <= '0;
      rd_v_q      <= 1'b0;
      rd_row_q    <= '0;
      coll_q      <= 1'b0;
      coll_data_q <= '0;
      coll_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      rd_v_q      <= rd_v_d;
      rd_row_q    <= rd_row_d;
      coll_q      <= coll_d;
      coll_data_q <= coll_data_d;
      coll_mask_q <= coll_mask_d;
    end
  end

  // Next state: walk every macro word once, then run.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      if (init_cnt_q == MDW'(MACRO_DEPTH - 1)) state_d = RUN;
      else init_cnt_d = init_cnt_q + MDW'(1);
    end
  end

  // FSM outputs: macro enables, addresses and write data for the current mode.
  always_comb begin
    in_init  = (state_q == INIT);
    rd_req   = !in_init && bus.R0_en;
    wr_req   = !in_init && bus.W0_en;
    collide  = rd_req && wr_req && (bus.R0_addr == bus.W0_addr);
    rd_row   = RW'(bus.R0_addr >> MDW);
    wr_row   = RW'(bus.W0_addr >> MDW);
    a_addr   = bus.R0_addr[MDW-1:0];
    b_addr   = in_init ? init_cnt_q : bus.W0_addr[MDW-1:0];
    b_data   = '0;
    b_bit_en = '0;
    if (in_init) begin
      b_bit_en[WIDTH-1:0] = '1;
    end else begin
      b_data[WIDTH-1:0]   = bus.W0_data;
      b_bit_en[WIDTH-1:0] = expand_mask(bus.W0_mask);
    end
    for (int r = 0; r < ROWS; r++) begin
      rd_en[r] = rd_req && (rd_row == RW'(r));
      wr_en[r] = in_init || (wr_req && (wr_row == RW'(r)));
    end
  end

  // Capture the row select and any same-address write alongside the macro read.
  always_comb begin
    rd_v_d      = rd_req;
    rd_row_d    = rd_req ? rd_row : rd_row_q;
    coll_d      = collide;
    coll_data_d = collide ? bus.W0_data : coll_data_q;
    coll_mask_d = collide ? bus.W0_mask : coll_mask_q;
  end

  // Row-select mux over macro outputs, then overlay forwarded write lanes.
  always_comb begin
    row_full = '0;
    for (int c = 0; c < COLS; c++) row_full[c*MACRO_WIDTH +: MACRO_WIDTH] = qa[rd_row_q][c];
    coll_bits = coll_q ? expand_mask(coll_mask_q) : '0;
    merged    = (row_full[WIDTH-1:0] & ~coll_bits) | (coll_data_q & coll_bits);
  end

  if (PW > WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^row_full[PW-1:WIDTH];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      mem_1r1w_masked_bank #(
        .MACRO_DEPTH (MACRO_DEPTH),
        .MACRO_WIDTH (MACRO_WIDTH)
      ) u_bank (
        .clock     (clock),
        .rd_en     (rd_en[r]),
        .rd_addr   (a_addr),
        .rd_data   (qa[r][c]),
        .wr_en     (wr_en[r]),
        .wr_addr   (b_addr),
        .wr_data   (b_data[c*MACRO_WIDTH +: MACRO_WIDTH]),
        .wr_bit_en (b_bit_en[c*MACRO_WIDTH +: MACRO_WIDTH])
      );
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    // Output stage loads on a valid read and holds otherwise.
    always_comb begin
      out_valid_d = rd_v_q;
      out_data_d  = rd_v_q ? merged : out_data_q;
    end

    // Output register.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        out_valid_q <= out_valid_d;
        out_data_q  <= out_data_d;
      end
    end

    assign bus.R0_data  = out_data_q;
    assign bus.R0_valid = out_valid_q;
  end else begin : g_out_comb
    assign bus.R0_data  = rd_v_q ? merged : '0;
    assign bus.R0_valid = rd_v_q;
  end

  assign bus.ready = (state_q == RUN);
  assign dbg_state = state_q;
endmodule
